// File: rtl/dsp_mac_pipe_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dsp_mac_pipe_pkg : shared defaults, beat flags and width/rounding helpers
// Rev 1.0
// ---------------------------------------------------------------------------
package dsp_mac_pipe_pkg;

   localparam int DEF_WIDTH     = 16;
   localparam int DEF_ACC_WIDTH = 40;
   localparam int DEF_OUT_WIDTH = 16;
   localparam int DEF_OUT_SHIFT = 15;

   typedef struct packed {
      logic first;
      logic last;
   } beat_flags_t;

   function automatic bit widths_ok(input int width, input int acc_width, input int out_width);
      return (acc_width >= 2 * width) && (out_width <= acc_width);
   endfunction

   // Half an output LSB, added before the shift to get round-half-up.
   function automatic logic [63:0] round_bias(input int shift);
      return (shift > 0) ? (64'd1 << (shift - 1)) : 64'd0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dsp_mac_pipe_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dsp_mac_pipe_if : beat input and result output bundle of the MAC pipeline
// Rev 1.0
// ---------------------------------------------------------------------------
interface dsp_mac_pipe_if
   import dsp_mac_pipe_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int OUT_WIDTH = DEF_OUT_WIDTH
) ();

   logic                 in_valid;
   logic [WIDTH-1:0]     in_a;
   logic [WIDTH-1:0]     in_b;
   logic                 in_first;
   logic                 in_last;
   logic                 out_valid;
   logic [OUT_WIDTH-1:0] out_data;
   logic                 out_sat;

   modport master (
      output in_valid, in_a, in_b, in_first, in_last,
      input  out_valid, out_data, out_sat
   );

   modport slave (
      input  in_valid, in_a, in_b, in_first, in_last,
      output out_valid, out_data, out_sat
   );

endinterface
`default_nettype wire

// File: rtl/dsp_round_sat.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dsp_round_sat : combinational round-half-up, arithmetic shift and clip
// Rev 1.0
// ---------------------------------------------------------------------------
module dsp_round_sat
   import dsp_mac_pipe_pkg::*;
#(
   parameter int ACC_WIDTH = DEF_ACC_WIDTH,
   parameter int OUT_WIDTH = DEF_OUT_WIDTH,
   parameter int OUT_SHIFT = DEF_OUT_SHIFT
) (
   input  wire logic signed [ACC_WIDTH-1:0] acc_i,
   output logic signed [OUT_WIDTH-1:0]      data_o,
   output logic                             sat_o
);

   // One guard bit so the bias add can never wrap.
   localparam logic signed [ACC_WIDTH:0] c_bias = (ACC_WIDTH+1)'(round_bias(OUT_SHIFT));
   localparam logic signed [ACC_WIDTH:0] c_max  =
      {{(ACC_WIDTH+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH:0] c_min  = ~c_max;

   logic signed [ACC_WIDTH:0] w_sum;
   logic signed [ACC_WIDTH:0] w_r;

   always_comb begin
      w_sum  = (ACC_WIDTH+1)'(acc_i) + c_bias;
      w_r    = w_sum >>> OUT_SHIFT;
      data_o = w_r[OUT_WIDTH-1:0];
      sat_o  = 1'b0;
      if (w_r > c_max) begin
         data_o = c_max[OUT_WIDTH-1:0];
         sat_o  = 1'b1;
      end else if (w_r < c_min) begin
         data_o = c_min[OUT_WIDTH-1:0];
         sat_o  = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/dsp_mac_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dsp_mac_pipe : 4-stage signed MAC with frame-delimited sums and round/sat
// Rev 1.0
// ---------------------------------------------------------------------------
module dsp_mac_pipe
   import dsp_mac_pipe_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int ACC_WIDTH = DEF_ACC_WIDTH,
   parameter int OUT_WIDTH = DEF_OUT_WIDTH,
   parameter int OUT_SHIFT = DEF_OUT_SHIFT
) (
   input  wire logic     clock,
   input  wire logic     reset_n,
   dsp_mac_pipe_if.slave bus
);

   if (!widths_ok(WIDTH, ACC_WIDTH, OUT_WIDTH)) begin : g_bad_width
      $error("dsp_mac_pipe: need ACC_WIDTH >= 2*WIDTH and OUT_WIDTH <= ACC_WIDTH");
   end

   logic                        v1_q;
   logic signed [WIDTH-1:0]     a1_q;
   logic signed [WIDTH-1:0]     b1_q;
   beat_flags_t                 f1_q;
   logic                        v2_q;
   logic signed [2*WIDTH-1:0]   prod2_q;
   logic signed [2*WIDTH-1:0]   prod2_d;
   beat_flags_t                 f2_q;
   logic signed [ACC_WIDTH-1:0] acc_q;
   logic signed [ACC_WIDTH-1:0] acc_d;
   logic                        emit3_q;
   logic                        out_valid_q;
   logic signed [OUT_WIDTH-1:0] out_data_q;
   logic                        out_sat_q;

   logic signed [ACC_WIDTH-1:0] w_prod_ext;
   logic signed [OUT_WIDTH-1:0] w_rs_data;
   logic                        w_rs_sat;

   // Kept behavioural so synthesis can map it onto the hard MAC tile.
   assign prod2_d    = $signed(a1_q) * $signed(b1_q);
   assign w_prod_ext = ACC_WIDTH'(prod2_q);

   always_comb begin
      acc_d = acc_q;
      if (v2_q) begin
         acc_d = f2_q.first ? w_prod_ext : acc_q + w_prod_ext;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         v1_q        <= 1'b0;
         a1_q        <= '0;
         b1_q        <= '0;
         f1_q        <= '0;
         v2_q        <= 1'b0;
         prod2_q     <= '0;
         f2_q        <= '0;
         acc_q       <= '0;
         emit3_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         v1_q <= bus.in_valid;
         if (bus.in_valid) begin
            a1_q <= bus.in_a;
            b1_q <= bus.in_b;
            f1_q <= '{first: bus.in_first, last: bus.in_last};
         end
         v2_q <= v1_q;
         if (v1_q) begin
            prod2_q <= prod2_d;
            f2_q    <= f1_q;
         end
         acc_q       <= acc_d;
         emit3_q     <= v2_q & f2_q.last;
         out_valid_q <= emit3_q;
         // Result and clip flag hold their value between pulses.
         if (emit3_q) begin
            out_data_q <= w_rs_data;
            out_sat_q  <= w_rs_sat;
         end
      end
   end

   dsp_round_sat #(
      .ACC_WIDTH (ACC_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .OUT_SHIFT (OUT_SHIFT)
   ) u_round_sat (
      .acc_i  (acc_q),
      .data_o (w_rs_data),
      .sat_o  (w_rs_sat)
   );

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sat   = out_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dsp_mac_pipe : directed vector table plus reset corner sequences
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_dsp_mac_pipe;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      bit          first;
      bit          last;
      int          gap;
      bit          chk;
      logic [15:0] data;
      bit          sat;
   } vec_t;

   typedef struct {
      int          due;
      logic [15:0] data;
      bit          sat;
   } exp_t;

   logic clock   = 1'b0;
   logic reset_n = 1'b1;
   int   cyc     = 0;
   int   n_cmp   = 0;
   int   n_err   = 0;

   logic [15:0] held_data = '0;
   bit          held_sat  = 1'b0;
   exp_t        exp_q[$];
   vec_t        vt[21];

   dsp_mac_pipe_if #(.WIDTH(16), .OUT_WIDTH(16)) bus ();

   dsp_mac_pipe dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Output monitor: every cycle is either a scheduled result or an idle hold.
   always @(posedge clock) begin
      exp_t e;
      #1;
      if (!reset_n) begin
         held_data = '0;
         held_sat  = 1'b0;
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         e = exp_q.pop_front();
         chk("out_valid", 32'(bus.out_valid), 32'd1);
         chk("out_data", 32'(bus.out_data), 32'(e.data));
         chk("out_sat", 32'(bus.out_sat), 32'(e.sat));
         held_data = e.data;
         held_sat  = e.sat;
      end else begin
         chk("out_valid_idle", 32'(bus.out_valid), 32'd0);
         chk("out_data_held", 32'(bus.out_data), 32'(held_data));
         chk("out_sat_held", 32'(bus.out_sat), 32'(held_sat));
      end
   end

   task automatic beat(input logic [15:0] a, input logic [15:0] b, input bit f, input bit l,
                       input bit c, input logic [15:0] d, input bit s);
      @(negedge clock);
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_first = f;
      bus.in_last  = l;
      if (c) exp_q.push_back('{due: cyc + 4, data: d, sat: s});
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clock);
         bus.in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() > 0 && n < 20) begin
         @(negedge clock);
         n++;
      end
      if (exp_q.size() > 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_timeout: actual %0d results pending, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic pulse_reset();
      @(negedge clock);
      bus.in_valid = 1'b0;
      reset_n      = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_a     = '0;
      bus.in_b     = '0;
      bus.in_first = 1'b0;
      bus.in_last  = 1'b0;
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data", 32'(bus.out_data), 32'd0);
      chk("rst_out_sat", 32'(bus.out_sat), 32'd0);
      reset_n = 1'b1;

      //          a         b         f  l  gap chk data      sat
      vt[0]  = '{16'h4000, 16'h4000, 1, 1, 0, 1, 16'h2000, 0};
      vt[1]  = '{16'h8000, 16'h8000, 1, 1, 0, 1, 16'h7FFF, 1};
      vt[2]  = '{16'h03E8, 16'h03E8, 1, 0, 1, 0, 16'h0000, 0};
      vt[3]  = '{16'h03E8, 16'h03E8, 0, 0, 1, 0, 16'h0000, 0};
      vt[4]  = '{16'h03E8, 16'h03E8, 0, 0, 1, 0, 16'h0000, 0};
      vt[5]  = '{16'h03E8, 16'h03E8, 0, 1, 0, 1, 16'd122,  0};
      vt[6]  = '{16'h0001, 16'h4000, 1, 1, 0, 1, 16'h0001, 0};
      vt[7]  = '{16'hFFFF, 16'h4000, 1, 1, 0, 1, 16'h0000, 0};
      vt[8]  = '{16'h0002, 16'h4000, 1, 1, 0, 1, 16'h0001, 0};
      vt[9]  = '{16'h0003, 16'h4000, 1, 1, 0, 1, 16'h0002, 0};
      vt[10] = '{16'hFFFD, 16'h4000, 1, 1, 0, 1, 16'hFFFF, 0};
      vt[11] = '{16'h0064, 16'h4000, 1, 1, 0, 1, 16'h0032, 0};
      vt[12] = '{16'hFF9C, 16'h4000, 1, 1, 0, 1, 16'hFFCE, 0};
      vt[13] = '{16'h0007, 16'h4000, 1, 1, 0, 1, 16'h0004, 0};
      vt[14] = '{16'h7FFF, 16'h4000, 1, 1, 0, 1, 16'h4000, 0};
      vt[15] = '{16'h8000, 16'h4000, 1, 1, 0, 1, 16'hC000, 0};
      vt[16] = '{16'h8000, 16'h7FFF, 1, 0, 0, 0, 16'h0000, 0};
      vt[17] = '{16'h8000, 16'h7FFF, 0, 1, 0, 1, 16'h8000, 1};
      vt[18] = '{16'h03E8, 16'h03E8, 1, 0, 0, 0, 16'h0000, 0};
      vt[19] = '{16'h4000, 16'h4000, 1, 1, 0, 1, 16'h2000, 0};
      vt[20] = '{16'h0001, 16'h4000, 0, 1, 0, 1, 16'h2001, 0};

      for (int i = 0; i < 21; i++) begin
         beat(vt[i].a, vt[i].b, vt[i].first, vt[i].last, vt[i].chk, vt[i].data, vt[i].sat);
         idle(vt[i].gap);
      end
      idle(1);
      drain();

      // Sum aborted by reset; the next single-beat sum must be clean.
      beat(16'h03E8, 16'h03E8, 1, 0, 0, 16'h0000, 0);
      beat(16'h03E8, 16'h03E8, 0, 0, 0, 16'h0000, 0);
      pulse_reset();
      beat(16'h03E8, 16'h03E8, 1, 1, 1, 16'h001F, 0);
      idle(1);
      drain();

      // A completed beat still in flight when reset hits must not emerge.
      beat(16'h4000, 16'h4000, 1, 1, 0, 16'h0000, 0);
      pulse_reset();
      idle(8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
